voice_mixer: RTL
================

# voice_mixer

- Sums the envelope-scaled operator outputs of all voices into one audio sample per sample tick.
- Each voice's signed operator sample is multiplied by its envelope magnitude, a 0..100 coefficient from the envelope generator where 100 means ×1.00.
- The accumulated sum is divided by 100 and saturated to the output width.
- Sits directly downstream of the per-voice envelope generators and operators, upstream of the audio codec serializer.

## Interface
Parameters:
- NUM_VOICES, 4, number of voices mixed per sample.
- SAMPLE_W, 16, signed operator sample and output width.
- MAG_W, 8, envelope magnitude width (unsigned).

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-low reset.
- sample_tick  in  1  one-Clk pulse at the audio sample rate.
- voice_sample  in  NUM_VOICES×SAMPLE_W  signed operator output per voice.
- voice_mag  in  NUM_VOICES×MAG_W  envelope magnitude per voice.
- mix_out  out  SAMPLE_W  signed mixed sample; holds its value between updates.
- mix_valid  out  1  one-Clk pulse when mix_out updates.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE → ACCUM → SCALE → DONE → IDLE.
- IDLE:
  - On sample_tick, snapshot all voice_sample and voice_mag values into registers.
  - Clear acc, set idx=0, go to ACCUM.
- ACCUM, one voice per cycle:
  - acc += snap_sample[idx] × min(snap_mag[idx], 100).
  - The product is signed SAMPLE_W × unsigned MAG_W.
  - After idx = NUM_VOICES−1, go to SCALE.
- Accumulator width:
  - ACC_W = SAMPLE_W + MAG_W + clog2(NUM_VOICES) + 1.
  - No internal overflow is possible.
- SCALE:
  - prod = acc × 5243, signed, ACC_W+14 bits.
  - scaled = prod >>> 19, arithmetic shift, i.e. floor. This approximates acc/100.
- DONE:
  - mix_out = scaled clamped to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
  - mix_valid = 1 for this cycle only, then return to IDLE.
- Magnitudes above 100 are clamped to 100 before multiplication.
- sample_tick while busy: the tick is dropped. No re-trigger, and the snapshot is unchanged.
- sample_tick on the same cycle DONE returns to IDLE: the tick is dropped, because the FSM is still not in IDLE.
- Reset values:
  - mix_out=0, mix_valid=0, busy=0, state=IDLE, acc=0, idx=0.
- Reset asserted mid-operation: abort to IDLE next edge with the reset values. No mix_valid pulse is produced.

## Timing
- Tick sampled at edge T: busy high from T+1.
- ACCUM occupies edges T+1 … T+NUM_VOICES.
- SCALE at edge T+NUM_VOICES+1.
- mix_out and mix_valid registered at edge T+NUM_VOICES+2. This is 6 cycles after the tick for NUM_VOICES=4.
- FSM back in IDLE after edge T+NUM_VOICES+3. The minimum tick spacing is NUM_VOICES+3 Clk cycles.
- Inputs are only sampled at the tick. Changes to voice_sample or voice_mag during ACCUM do not affect the result.

## Configuration
- VOICE_MIXER_OVERRUN_EN defined:
  - Adds output overrun_cnt (8 bits), reset to 0.
  - Increments on every dropped sample_tick (tick while not IDLE).
  - Saturates at 255 and clears only on reset.
- Undefined: the port and counter are absent. Dropped ticks are silent.

## Structure
- Package voice_mixer_pkg holds:
  - state enum (IDLE, ACCUM, SCALE, DONE)
  - SCALE_MUL=5243, SCALE_SHIFT=19, MAG_MAX=100
  - ACC_W function of the parameters
- One sub-module, voice_mac: per-cycle clamp of the magnitude, signed×unsigned multiply, and accumulate with synchronous clear.
- FSM, snapshot registers, scale and saturate stay in voice_mixer.

## Test plan
- Single voice 10000, mag 100, others mag 0; tick → mix_out=10000, mix_valid exactly 6 cycles after the tick.
- Voice0 −10000, mag 50, others mag 0 → mix_out=−5001 (floor rounding).
- All four voices 32767, mag 100 → mix_out=32767 (saturated); all four −32768, mag 100 → −32768.
- Voice0 1000, mag 255 → treated as 100, mix_out=1000; a second tick 2 cycles after the first is ignored: one mix_valid pulse only, and overrun_cnt=1 when VOICE_MIXER_OVERRUN_EN is defined.
- Reset low during ACCUM → no mix_valid, mix_out=0, busy=0 next cycle; a following tick produces a correct result.
- voice_sample changed every cycle during ACCUM → output equals the value computed from the snapshot taken at the tick.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg: shared types and constants for the voice mixer.
//   state_t    - mixer FSM states
//   SCALE_MUL  - fixed-point reciprocal of 100 (5243 / 2^19 ~= 0.01)
//   SCALE_SHIFT, MAG_MAX - shift paired with SCALE_MUL, magnitude ceiling
//   acc_w()    - accumulator width that cannot overflow for the given sizes
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SCALE_MUL   = 5243;
    localparam int SCALE_SHIFT = 19;
    localparam int MAG_MAX     = 100;

    function automatic int acc_w(input int sample_w, input int mag_w, input int num_voices);
        return sample_w + mag_w + $clog2(num_voices) + 1;
    endfunction

endpackage

// File: rtl/voice_mac.sv
// voice_mac: clamp a voice magnitude to MAG_MAX, multiply it (unsigned) by the
// signed voice sample and accumulate the product.
// Ports:
//   Clk, Reset   - clock, synchronous active-low reset
//   clr          - synchronous clear of the accumulator (start of a mix)
//   en           - add this cycle's product
//   sample, mag  - current voice sample (signed) and magnitude (unsigned)
//   acc          - running signed sum
module voice_mac
    import voice_mixer_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int MAG_W    = 8,
    parameter int ACC_W    = 27
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [MAG_W-1:0]    mag,
    output logic signed [ACC_W-1:0]    acc
);

    logic        [MAG_W-1:0]        mag_c;
    logic signed [SAMPLE_W+MAG_W:0] product;

    always_comb begin
        mag_c   = (mag > MAG_W'(MAG_MAX)) ? MAG_W'(MAG_MAX) : mag;
        // Zero-extend the magnitude so the multiply stays signed x unsigned.
        product = sample * $signed({1'b0, mag_c});
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(product);
    end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: on each sample_tick, snapshots all voices, accumulates
// sample x min(mag,100) one voice per cycle, divides by 100 (floor) and
// saturates to SAMPLE_W bits.
// Ports:
//   Clk, Reset    - clock, synchronous active-low reset
//   sample_tick   - one-cycle pulse at the audio sample rate
//   voice_sample  - signed operator sample per voice
//   voice_mag     - unsigned envelope magnitude per voice (100 = x1.00)
//   mix_out       - signed mixed sample, held between updates
//   mix_valid     - one-cycle pulse when mix_out updates
//   busy          - high while the FSM is not IDLE
//   overrun_cnt   - saturating count of dropped ticks (only with
//                   VOICE_MIXER_OVERRUN_EN defined)
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int MAG_W      = 8
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 sample_tick,
    input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  voice_sample,
    input  logic [NUM_VOICES-1:0][MAG_W-1:0]     voice_mag,
`ifdef VOICE_MIXER_OVERRUN_EN
    output logic [7:0]                           overrun_cnt,
`endif
    output logic signed [SAMPLE_W-1:0]           mix_out,
    output logic                                 mix_valid,
    output logic                                 busy
);

    localparam int ACC_W  = acc_w(SAMPLE_W, MAG_W, NUM_VOICES);
    localparam int PROD_W = ACC_W + 14;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    state_t                              state;
    logic [IDX_W-1:0]                    idx;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0] snap_sample;
    logic [NUM_VOICES-1:0][MAG_W-1:0]    snap_mag;
    logic signed [ACC_W-1:0]             acc;
    logic signed [ACC_W-1:0]             scaled;
    logic signed [PROD_W-1:0]            prod;
    logic                                start;

    assign start = (state == IDLE) && sample_tick;

    voice_mac #(
        .SAMPLE_W (SAMPLE_W),
        .MAG_W    (MAG_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (start),
        .en     (state == ACCUM),
        .sample ($signed(snap_sample[idx])),
        .mag    (snap_mag[idx]),
        .acc    (acc)
    );

    // acc * 5243 >>> 19 approximates acc / 100 with floor rounding.
    always_comb begin
        prod = $signed({{(PROD_W - ACC_W){acc[ACC_W-1]}}, acc}) * $signed(PROD_W'(SCALE_MUL));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            idx         <= '0;
            snap_sample <= '0;
            snap_mag    <= '0;
            scaled      <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_sample <= voice_sample;
                        snap_mag    <= voice_mag;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        state <= SCALE;
                end
                SCALE: begin
                    scaled <= ACC_W'(prod >>> SCALE_SHIFT);
                    state  <= DONE;
                end
                DONE: begin
                    if (scaled > SAT_MAX)
                        mix_out <= SAMPLE_W'(SAT_MAX);
                    else if (scaled < SAT_MIN)
                        mix_out <= SAMPLE_W'(SAT_MIN);
                    else
                        mix_out <= SAMPLE_W'(scaled);
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VOICE_MIXER_OVERRUN_EN
    // Any tick seen outside IDLE is dropped; count it, saturating at 255.
    always_ff @(posedge Clk) begin
        if (!Reset)
            overrun_cnt <= '0;
        else if (sample_tick && (state != IDLE) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

endmodule
